// File: rtl/obstacle_pkg.sv
// Shared types for the obstacle frame scheduler: obstacle word layout,
// captured list entry and scheduler state encoding.
package obstacle_pkg;

  localparam int OBSTACLE_WORD_W = 16;
  localparam int IDX_W           = 6;

  typedef enum logic [2:0] {
    NONE,
    LOW_BARRIER,
    HIGH_BARRIER,
    MID_BARRIER,
    TRAIN,
    RAMP,
    MOVING_CAR
  } obstacle_type_e;

  typedef struct packed {
    obstacle_type_e obs_type;
    logic [1:0]     lane;
    logic [10:0]    depth;
  } obstacle_t;

  typedef struct packed {
    logic      first_row;
    obstacle_t obstacle;
  } list_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVATE,
    S_COLLECT,
    S_SWAP
  } sched_state_e;

endpackage

// File: rtl/obstacle_frame_scheduler_if.sv
// Generator, read-port and status signals of the obstacle frame scheduler.
// master = scheduler side, slave = generator / readers side.
interface obstacle_frame_scheduler_if;
  import obstacle_pkg::*;

  logic                       frame_start;
  logic                       gen_activate;
  logic                       gen_valid;
  logic                       gen_first_row;
  logic [OBSTACLE_WORD_W-1:0] gen_obstacle;
  logic                       gen_done;
  logic [1:0]                 rd_req;
  logic [IDX_W-1:0]           rd_idx0;
  logic [IDX_W-1:0]           rd_idx1;
  logic [1:0]                 rd_gnt;
  logic [1:0]                 rd_dvalid;
  logic [OBSTACLE_WORD_W:0]   rd_data;
  logic [IDX_W-1:0]           list_count;
  logic                       list_ready;
  logic                       frame_skip;
  logic                       overflow;
  logic                       timeout_err;

  modport master (
    input  frame_start, gen_valid, gen_first_row, gen_obstacle, gen_done,
           rd_req, rd_idx0, rd_idx1,
    output gen_activate, rd_gnt, rd_dvalid, rd_data, list_count,
           list_ready, frame_skip, overflow, timeout_err
  );

  modport slave (
    output frame_start, gen_valid, gen_first_row, gen_obstacle, gen_done,
           rd_req, rd_idx0, rd_idx1,
    input  gen_activate, rd_gnt, rd_dvalid, rd_data, list_count,
           list_ready, frame_skip, overflow, timeout_err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered one-hot grant. Priority
// only moves when both ports contend, so lone requests never disturb it.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] next_gnt,
  output logic [1:0] gnt
);

  logic prio;

  always_comb begin
    next_gnt = 2'b00;
    case (req)
      2'b01:   next_gnt = 2'b01;
      2'b10:   next_gnt = 2'b10;
      2'b11:   next_gnt = prio ? 2'b10 : 2'b01;
      default: next_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt  <= 2'b00;
      prio <= 1'b0;
    end else begin
      gnt <= next_gnt;
      if (req == 2'b11) prio <= ~prio;
    end
  end

endmodule

// File: rtl/obstacle_frame_scheduler.sv
// Per-frame sequencer: activates the generator, captures its stream into a
// ping-pong list, publishes on done. Optional macro: OSCHED_DEPTH_FILTER_EN.
module obstacle_frame_scheduler
  import obstacle_pkg::*;
#(
  parameter int MAX_OBSTACLES  = 48,
  parameter int TIMEOUT_CYCLES = 4096
`ifdef OSCHED_DEPTH_FILTER_EN
  ,
  parameter int DEPTH_LIMIT    = 1023
`endif
) (
  input logic                        clk,
  input logic                        rst,
  obstacle_frame_scheduler_if.master bus
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0]   MAX_PTR    = IDX_W'(MAX_OBSTACLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   wr_ptr;
  logic [TIMER_W-1:0] timer;
  logic               front_sel;
  logic [IDX_W-1:0]   list_count_q;
  logic               frame_skip_q, overflow_q, timeout_q;
  list_entry_t        buf_a [MAX_OBSTACLES];
  list_entry_t        buf_b [MAX_OBSTACLES];
  list_entry_t        entry_in;
  logic               accept, capture, drop;

  assign entry_in = list_entry_t'({bus.gen_first_row, bus.gen_obstacle});

`ifdef OSCHED_DEPTH_FILTER_EN
  assign accept = bus.gen_valid && (entry_in.obstacle.depth <= 11'(DEPTH_LIMIT));
`else
  assign accept = bus.gen_valid;
`endif

  assign capture = (state_q == S_COLLECT) && accept && (wr_ptr != MAX_PTR);
  assign drop    = (state_q == S_COLLECT) && accept && (wr_ptr == MAX_PTR);

  always_comb begin
    state_d          = state_q;
    bus.gen_activate = 1'b0;
    bus.list_ready   = 1'b0;
    case (state_q)
      S_IDLE:     if (bus.frame_start) state_d = S_ACTIVATE;
      S_ACTIVATE: begin
        bus.gen_activate = 1'b1;
        state_d          = S_COLLECT;
      end
      S_COLLECT: begin
        if (bus.gen_done)            state_d = S_SWAP;
        else if (timer == TIMER_LAST) state_d = S_IDLE;
      end
      S_SWAP: begin
        bus.list_ready = 1'b1;
        state_d        = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr       <= '0;
      timer        <= '0;
      front_sel    <= 1'b0;
      list_count_q <= '0;
      frame_skip_q <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.frame_start && state_q != S_IDLE) frame_skip_q <= 1'b1;
      if (state_q == S_ACTIVATE) begin
        wr_ptr <= '0;
        timer  <= '0;
      end
      if (state_q == S_COLLECT) begin
        timer <= timer + 1'b1;
        if (capture) wr_ptr <= wr_ptr + 1'b1;
        if (drop) overflow_q <= 1'b1;
        if (!bus.gen_done && timer == TIMER_LAST) timeout_q <= 1'b1;
      end
      if (state_q == S_SWAP) begin
        front_sel    <= ~front_sel;
        list_count_q <= wr_ptr;
      end
    end
  end

  // front_sel = 0 means A is published and B is being filled.
  always_ff @(posedge clk) begin
    if (capture) begin
      if (front_sel) buf_a[wr_ptr] <= entry_in;
      else           buf_b[wr_ptr] <= entry_in;
    end
  end

  logic [1:0]       next_gnt, rd_gnt;
  logic [IDX_W-1:0] rd_idx_q, rd_cnt_q;
  logic             rd_sel_q;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.rd_req),
    .next_gnt (next_gnt),
    .gnt      (rd_gnt)
  );

  // The grant snapshots index, buffer and count so a same-cycle swap reads old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx_q      <= '0;
      rd_cnt_q      <= '0;
      rd_sel_q      <= 1'b0;
      bus.rd_dvalid <= 2'b00;
      bus.rd_data   <= '0;
    end else begin
      if (next_gnt != 2'b00) begin
        rd_idx_q <= next_gnt[1] ? bus.rd_idx1 : bus.rd_idx0;
        rd_sel_q <= front_sel;
        rd_cnt_q <= list_count_q;
      end
      bus.rd_dvalid <= rd_gnt;
      if (rd_gnt != 2'b00 && rd_idx_q < rd_cnt_q)
        bus.rd_data <= rd_sel_q ? buf_b[rd_idx_q] : buf_a[rd_idx_q];
      else
        bus.rd_data <= '0;
    end
  end

  assign bus.rd_gnt      = rd_gnt;
  assign bus.list_count  = list_count_q;
  assign bus.frame_skip  = frame_skip_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_obstacle_frame_scheduler.sv
// Scoreboard bench for obstacle_frame_scheduler: stimulus pushes expected
// grants, reads and publish counts; monitors pop and compare.
module tb_obstacle_frame_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   act_count = 0;

  logic [1:0]  exp_gnt_q [$];
  logic [18:0] exp_read_q [$];
  logic [5:0]  exp_pub_q [$];

  always #5 clk = ~clk;

  obstacle_frame_scheduler_if bus ();
  obstacle_frame_scheduler_if bus2 ();

  obstacle_frame_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  obstacle_frame_scheduler #(.TIMEOUT_CYCLES(16)) dut_short (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  function automatic logic [15:0] word_of(int i);
    logic [2:0]  t = 3'(i % 7);
    logic [1:0]  l = 2'(i % 3);
    logic [10:0] d = 11'(i * 13 + 5);
    return {t, l, d};
  endfunction

  function automatic logic [16:0] entry_of(int i);
    return {(i == 0), word_of(i)};
  endfunction

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check_output("activate_after_frame_start", 32'(bus.gen_activate), 32'd1);
    tick();
  endtask

  task automatic emit(int n);
    for (int i = 0; i < n; i++) begin
      bus.gen_valid     = 1'b1;
      bus.gen_first_row = (i == 0);
      bus.gen_obstacle  = word_of(i);
      tick();
    end
    bus.gen_valid     = 1'b0;
    bus.gen_first_row = 1'b0;
    bus.gen_obstacle  = '0;
  endtask

  task automatic finish_frame(logic [5:0] expected_count, logic with_tick);
    exp_pub_q.push_back(expected_count);
    bus.gen_done    = 1'b1;
    bus.frame_start = with_tick;
    tick();
    bus.gen_done    = 1'b0;
    bus.frame_start = 1'b0;
    check_output("list_ready_after_done", 32'(bus.list_ready), 32'd1);
    tick();
  endtask

  task automatic apply_stimulus(int port, logic [5:0] idx, logic [16:0] expected);
    logic [1:0] onehot = (port == 0) ? 2'b01 : 2'b10;
    exp_gnt_q.push_back(onehot);
    exp_read_q.push_back({onehot, expected});
    bus.rd_req = onehot;
    if (port == 0) bus.rd_idx0 = idx;
    else           bus.rd_idx1 = idx;
    tick();
    bus.rd_req = 2'b00;
    tick();
    tick();
  endtask

  // Grant / read-data monitor; dvalid must echo the previous cycle's grant.
  initial begin
    logic [1:0]  prev_gnt = 2'b00;
    logic [18:0] exp;
    forever begin
      @(negedge clk);
      if (bus.gen_activate) act_count++;
      if (bus.rd_gnt != 2'b00) begin
        if (exp_gnt_q.size() == 0) check_output("unexpected_grant", 32'(bus.rd_gnt), 32'd0);
        else check_output("grant", 32'(bus.rd_gnt), 32'(exp_gnt_q.pop_front()));
      end
      if (bus.rd_dvalid != 2'b00) begin
        check_output("dvalid_lags_grant", 32'(bus.rd_dvalid), 32'(prev_gnt));
        if (exp_read_q.size() == 0) begin
          check_output("unexpected_dvalid", 32'(bus.rd_dvalid), 32'd0);
        end else begin
          exp = exp_read_q.pop_front();
          check_output("dvalid_port", 32'(bus.rd_dvalid), 32'(exp[18:17]));
          check_output("rd_data", 32'(bus.rd_data), 32'(exp[16:0]));
        end
      end
      prev_gnt = bus.rd_gnt;
    end
  end

  // Publish monitor: list_count is updated by the swap, so compare a cycle later.
  initial begin
    logic [5:0] exp;
    forever begin
      @(negedge clk);
      if (bus.list_ready) begin
        if (exp_pub_q.size() == 0) begin
          check_output("unexpected_list_ready", 32'd1, 32'd0);
        end else begin
          exp = exp_pub_q.pop_front();
          @(negedge clk);
          check_output("list_count_published", 32'(bus.list_count), 32'(exp));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ready_seen;
    {bus.frame_start, bus.gen_valid, bus.gen_first_row, bus.gen_done} = '0;
    bus.gen_obstacle = '0;
    bus.rd_req = '0; bus.rd_idx0 = '0; bus.rd_idx1 = '0;
    {bus2.frame_start, bus2.gen_valid, bus2.gen_first_row, bus2.gen_done} = '0;
    bus2.gen_obstacle = '0;
    bus2.rd_req = '0; bus2.rd_idx0 = '0; bus2.rd_idx1 = '0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_output("reset_list_count", 32'(bus.list_count), 32'd0);
    check_output("reset_flags", 32'({bus.frame_skip, bus.overflow, bus.timeout_err, bus.list_ready}), 32'd0);
    check_output("reset_read_outputs", 32'({bus.rd_gnt, bus.rd_dvalid, bus.gen_activate}), 32'd0);

    // Basic capture and publish
    start_frame();
    emit(5);
    finish_frame(6'd5, 1'b0);
    check_output("basic_no_overflow", 32'(bus.overflow), 32'd0);
    apply_stimulus(0, 6'd4, entry_of(4));

    // Contention: both ports held for four cycles
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10);
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10);
    exp_read_q.push_back({2'b01, entry_of(0)}); exp_read_q.push_back({2'b10, entry_of(1)});
    exp_read_q.push_back({2'b01, entry_of(0)}); exp_read_q.push_back({2'b10, entry_of(1)});
    bus.rd_idx0 = 6'd0;
    bus.rd_idx1 = 6'd1;
    bus.rd_req  = 2'b11;
    for (int i = 0; i < 4; i++) tick();
    bus.rd_req = 2'b00;
    tick();
    tick();

    // Overflow: 50 entries into a 48-deep list
    start_frame();
    emit(50);
    finish_frame(6'd48, 1'b0);
    check_output("overflow_set", 32'(bus.overflow), 32'd1);
    apply_stimulus(0, 6'd47, entry_of(47));
    apply_stimulus(1, 6'd48, 17'd0);

    // Frame skip during COLLECT and coincident with done
    check_output("frame_skip_clear", 32'(bus.frame_skip), 32'd0);
    start_frame();
    emit(2);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    finish_frame(6'd2, 1'b1);
    tick();
    check_output("frame_skip_set", 32'(bus.frame_skip), 32'd1);
    check_output("activations_after_skip", 32'(act_count), 32'd3);
    apply_stimulus(1, 6'd1, entry_of(1));

    // Reset mid-frame
    start_frame();
    emit(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midreset_list_count", 32'(bus.list_count), 32'd0);
    check_output("midreset_flags", 32'({bus.frame_skip, bus.overflow, bus.timeout_err, bus.list_ready}), 32'd0);
    check_output("midreset_read_outputs", 32'({bus.rd_gnt, bus.rd_dvalid, bus.rd_data, bus.gen_activate}), 32'd0);
    tick();
    start_frame();
    emit(3);
    finish_frame(6'd3, 1'b0);
    apply_stimulus(0, 6'd2, entry_of(2));
    apply_stimulus(1, 6'd3, 17'd0);
    check_output("post_reset_no_overflow", 32'(bus.overflow), 32'd0);

    // Timeout on the short-timeout instance
    bus2.frame_start = 1'b1;
    tick();
    bus2.frame_start = 1'b0;
    check_output("short_activate", 32'(bus2.gen_activate), 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      bus2.gen_valid = 1'b1;
      bus2.gen_obstacle = word_of(i);
      tick();
    end
    bus2.gen_valid = 1'b0;
    bus2.gen_done = 1'b1;
    tick();
    bus2.gen_done = 1'b0;
    tick();
    check_output("short_list_count", 32'(bus2.list_count), 32'd2);
    check_output("short_timeout_clear", 32'(bus2.timeout_err), 32'd0);
    bus2.frame_start = 1'b1;
    tick();
    bus2.frame_start = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus2.list_ready) ready_seen++;
    end
    check_output("timeout_err_set", 32'(bus2.timeout_err), 32'd1);
    check_output("timeout_no_swap", 32'(ready_seen), 32'd0);
    check_output("timeout_count_kept", 32'(bus2.list_count), 32'd2);
    check_output("timeout_no_skip", 32'(bus2.frame_skip), 32'd0);
    bus2.frame_start = 1'b1;
    tick();
    bus2.frame_start = 1'b0;
    check_output("timeout_back_to_idle", 32'(bus2.gen_activate), 32'd1);

    for (int i = 0; i < 4; i++) tick();
    check_output("activations_total", 32'(act_count), 32'd5);
    check_output("grant_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
    check_output("read_queue_drained", 32'(exp_read_q.size()), 32'd0);
    check_output("publish_queue_drained", 32'(exp_pub_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obstacle_frame_scheduler.md
Name: obstacle_frame_scheduler

Overview:
- Per-frame sequencer for the obstacle generator.
- On each frame tick it pulses the generator's activate, then captures the generator's valid obstacle stream into a ping-pong obstacle list.
- On the generator's done it swaps buffers and publishes the list.
- Read access to the published list is arbitrated round-robin between the renderer (port 0) and the collision checker (port 1).

Parameters:
- MAX_OBSTACLES, 48: entries per buffer (16 rows x 3 lanes).
- TIMEOUT_CYCLES, 4096: maximum cycles from activate to done before the frame is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- frame_start  in  1  one-cycle frame tick
- gen_activate  out  1  one-cycle pulse to generator activate
- gen_valid  in  1  generator entry valid
- gen_first_row  in  1  generator first_row
- gen_obstacle  in  16  generator obstacle word {type[2:0], lane[1:0], depth[10:0]}
- gen_done  in  1  generator done
- rd_req  in  2  read request per port, held until granted
- rd_idx0  in  6  entry index, port 0
- rd_idx1  in  6  entry index, port 1
- rd_gnt  out  2  one-hot grant, one cycle
- rd_dvalid  out  2  one-hot data valid, one cycle after grant
- rd_data  out  17  {first_row, obstacle}
- list_count  out  6  number of entries in the published buffer
- list_ready  out  1  one-cycle pulse on swap
- frame_skip  out  1  sticky: frame_start arrived while busy
- overflow  out  1  sticky: more than MAX_OBSTACLES entries captured in a frame
- timeout_err  out  1  sticky: done not seen within TIMEOUT_CYCLES

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset:
  - All outputs 0; list_count 0; front buffer = A.
  - State IDLE; arbiter priority = port 0.
  - Buffer contents undefined but unreadable, because list_count = 0.
  - Reset mid-frame abandons capture. The generator is not reset by this block.
- States:
  - IDLE: on frame_start -> ACTIVATE.
  - ACTIVATE: gen_activate = 1 for exactly this cycle; wr_ptr <= 0; timer <= 0 -> COLLECT.
  - COLLECT:
    - Each gen_valid cycle writes {gen_first_row, gen_obstacle} to back[wr_ptr] and increments wr_ptr.
    - If wr_ptr == MAX_OBSTACLES, the entry is dropped and overflow is set.
    - gen_done -> SWAP.
    - timer reaching TIMEOUT_CYCLES-1 -> set timeout_err, return to IDLE, no swap.
  - SWAP: front <= back; list_count <= wr_ptr; list_ready = 1 -> IDLE.
- Frame tick rules:
  - frame_start in any state other than IDLE sets frame_skip and is otherwise ignored. There is no queueing.
  - frame_start in the same cycle as gen_done is treated as a skip.
- Simultaneous gen_valid and gen_done: the entry is captured, then the state goes to SWAP.
- Arbiter:
  - Considers rd_req each cycle while no grant is pending.
  - Single requester: granted.
  - Both requesting: the port holding priority wins; priority then passes to the other port.
  - At most one grant per cycle. Back-to-back grants are allowed.
  - The grant registers the port's index and the current front-buffer select.
  - rd_data and rd_dvalid follow one cycle later.
  - A swap in the cycle of a grant does not affect that read (old buffer).
  - Index >= list_count returns rd_data = 0 with rd_dvalid still asserted.
- Widths:
  - wr_ptr, list_count and indices are 6 bits; MAX_OBSTACLES must be <= 63.
  - timer is $clog2(TIMEOUT_CYCLES) bits.

Optional Feature:
- Macro: OSCHED_DEPTH_FILTER_EN.
- When defined:
  - Entries whose depth[10:0] > DEPTH_LIMIT are not written in COLLECT.
  - DEPTH_LIMIT is an extra parameter, default 1023.
  - These entries do not advance wr_ptr and do not count toward overflow.
- When undefined: every gen_valid entry is captured; DEPTH_LIMIT does not exist.

Decomposition:
- Package obstacle_pkg:
  - obstacle type enum (NONE, LOW_BARRIER, HIGH_BARRIER, MID_BARRIER, TRAIN, RAMP, MOVING_CAR).
  - obstacle_t packed struct {type, lane, depth}.
  - list_entry_t {first_row, obstacle_t}.
  - Scheduler state enum; OBSTACLE_WORD_W = 16.
- Sub-module rr_arbiter2: 2-way round-robin with registered grant.
- Buffers: two arrays inline in the top module.

Test Plan:
- Basic capture and publish:
  - Stimulus: frame_start; generator model emits 5 valids, then done.
  - Required: gen_activate pulses once the cycle after frame_start; list_ready one cycle after done; list_count = 5; a port-0 read of idx 4 returns the 5th word.
- Contention:
  - Stimulus: rd_req = 2'b11 held, idx0 = 0, idx1 = 1, for 4 cycles.
  - Required: grants alternate 01, 10, 01, 10; each rd_dvalid lags its grant by 1 cycle with the matching data.
- Overflow:
  - Stimulus: 50 valids, then done.
  - Required: list_count = 48; overflow = 1; entry 47 = 48th word.
- Frame skip:
  - Stimulus: frame_start during COLLECT, and frame_start coincident with gen_done.
  - Required: frame_skip = 1; no extra gen_activate.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 16; no done for 20 cycles.
  - Required: timeout_err = 1; state IDLE; list_count unchanged from the previous frame.
- Reset mid-frame:
  - Stimulus: rst during COLLECT after 3 valids.
  - Required: all outputs 0; list_count 0; the next frame captures normally.
